// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, fetch granularity
// and the queue entry layout (PC alongside the fetched word).
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and an occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // pointer and count bookkeeping; clear wins over any push/pop in the same cycle
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues in-order word requests to imem, buffers returned words with
// their PCs and hands them to decode on valid/ready. A redirect flushes the queue;
// responses already in flight at that point are counted down and thrown away.
//
//   state | meaning
//   RUN   | issuing requests and queueing responses
//   DRAIN | waiting out stale responses after a redirect, no new requests
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] out_after_rsp;
  logic [CW-1:0] drop_after_rsp;
  logic          rsp_live;
  logic          credit_ok;
  logic          gnt_fire;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // a response only counts against a request that is actually outstanding
  assign rsp_live       = imem_rvalid & (outstanding != '0);
  assign out_after_rsp  = outstanding - CW'(rsp_live);
  assign drop_after_rsp = drop_cnt - CW'(imem_rvalid & (drop_cnt != '0));

  // queued entries plus in-flight requests never exceed the queue size,
  // so a returning word always has room
  assign credit_ok = (({1'b0, occupancy} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                   && (outstanding < CW'(MAX_OUTSTANDING));

  assign imem_req    = reset & ~redirect & (state == RUN) & credit_ok;
  assign imem_addr   = fetch_pc;
  assign gnt_fire    = imem_req & imem_gnt;
  assign push        = reset & ~redirect & (state == RUN) & rsp_live;
  assign instr_valid = reset & ~redirect & ~fifo_empty;
  assign pop         = instr_valid & instr_ready;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign push_entry  = '{pc: rsp_pc, instr: imem_rdata};

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .clear(~reset | redirect),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .dout (head),
    .count(occupancy),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // FSM, PC registers and the outstanding/drop counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc & ~32'h3;
      rsp_pc      <= redirect_pc & ~32'h3;
      drop_cnt    <= out_after_rsp;
      outstanding <= out_after_rsp;
      state       <= (out_after_rsp != '0) ? DRAIN : RUN;
    end else begin
      case (state)
        RUN: begin
          if (gnt_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
          if (push) rsp_pc <= rsp_pc + 32'(INSTR_BYTES);
          outstanding <= outstanding + CW'(gnt_fire) - CW'(push);
        end
        DRAIN: begin
          drop_cnt    <= drop_after_rsp;
          outstanding <= drop_after_rsp;
          if (drop_after_rsp == '0) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // imem must not return more words than were requested, and the credit
  // scheme must never let a push meet a full queue
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> !fifo_full);

endmodule
